// File: rtl/seq_divider.sv
// Iterative restoring unsigned divider: one trial subtraction per clock, MSB first,
// with a start/busy/done handshake toward the ALU control sequencer.
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] dvsr_q, q_q, quot_q, rem_q;
  logic [WIDTH:0]   p_q;
  logic             dbz_q;

  logic [WIDTH:0]   p_sh, diff, p_d;
  logic [WIDTH-1:0] q_d;
  logic             borrow;

  // One restoring step: shift P/Q left, trial-subtract, keep the shifted P on borrow.
  always_comb begin
    p_sh   = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
    diff   = p_sh - {1'b0, dvsr_q};
    borrow = diff[WIDTH];
    p_d    = borrow ? p_sh : diff;
    q_d    = {q_q[WIDTH-2:0], ~borrow};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvsr_q  <= '0;
      q_q     <= '0;
      p_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            q_q    <= dividend;
            dvsr_q <= divisor;
            p_q    <= '0;
            cnt_q  <= '0;
            if (divisor == '0) begin
              quot_q  <= '1;
              rem_q   <= dividend;
              dbz_q   <= 1'b1;
              state_q <= DONE;
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          p_q   <= p_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + CW'(1);
          // Results are published only on the final iteration so they hold between ops.
          if (cnt_q == LAST) begin
            quot_q  <= q_d;
            rem_q   <= p_d[WIDTH-1:0];
            dbz_q   <= 1'b0;
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases, exhaustive 4-bit sweep and
// random 8-bit traffic against a plain-arithmetic reference model.
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start4 = 1'b0, start8 = 1'b0;
  logic [3:0] dvd4 = '0, dvs4 = '0, quo4, rem4;
  logic [7:0] dvd8 = '0, dvs8 = '0, quo8, rem8;
  logic       busy4, done4, dbz4, busy8, done8, dbz8;

  int n_chk = 0, n_fail = 0;
  int done_cnt4 = 0, done_cnt8 = 0;
  int unsigned prev_q4 = 0, prev_r4 = 0, prev_z4 = 0;
  int unsigned prev_q8 = 0, prev_r8 = 0, prev_z8 = 0;

  seq_divider #(.WIDTH(4)) u_div4 (
    .clk(clk), .rst(rst), .start(start4), .dividend(dvd4), .divisor(dvs4),
    .quotient(quo4), .remainder(rem4), .busy(busy4), .done(done4), .div_by_zero(dbz4)
  );

  seq_divider #(.WIDTH(8)) u_div8 (
    .clk(clk), .rst(rst), .start(start8), .dividend(dvd8), .divisor(dvs8),
    .quotient(quo8), .remainder(rem8), .busy(busy8), .done(done8), .div_by_zero(dbz8)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done4) done_cnt4++;
    if (done8) done_cnt8++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model(input int w, input int unsigned a, input int unsigned b,
                                output int unsigned q, output int unsigned r,
                                output int unsigned z);
    if (b == 0) begin
      q = (1 << w) - 1; r = a; z = 1;
    end else begin
      q = a / b; r = a % b; z = 0;
    end
  endfunction

  // Wait (bounded) until done4 is seen; cyc counts edges after the accepting edge.
  task automatic wait4(input bit disturb, output int cyc);
    cyc = 0;
    while (!done4 && cyc < 40) begin
      if (disturb && cyc == 1) begin
        start4 = 1'b1; dvd4 = 4'd7; dvs4 = 4'd7;
      end else if (disturb) begin
        start4 = 1'b0; dvd4 = 4'($urandom); dvs4 = 4'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic finish4(input string tag, input int unsigned a, input int unsigned b,
                         input int cyc, input int d0);
    int unsigned q, r, z;
    model(4, a, b, q, r, z);
    chk({tag, "_lat"}, cyc, (b == 0) ? 0 : 4);
    chk({tag, "_quo"}, quo4, q);
    chk({tag, "_rem"}, rem4, r);
    chk({tag, "_dbz"}, dbz4, z);
    prev_q4 = q; prev_r4 = r; prev_z4 = z;
    @(posedge clk); #1;
    chk({tag, "_done_once"}, done_cnt4 - d0, 1);
    chk({tag, "_idle"}, {busy4, done4}, 0);
  endtask

  task automatic run4(input int unsigned a, input int unsigned b, input bit disturb,
                      input string tag);
    int cyc, d0;
    @(negedge clk);
    start4 = 1'b1; dvd4 = 4'(a); dvs4 = 4'(b);
    d0 = done_cnt4;
    @(posedge clk); #1;
    start4 = 1'b0;
    chk({tag, "_busy"}, busy4, 1);
    if (b != 0) begin
      chk({tag, "_hold_q"}, quo4, prev_q4);
      chk({tag, "_hold_r"}, rem4, prev_r4);
      chk({tag, "_hold_z"}, dbz4, prev_z4);
    end
    wait4(disturb, cyc);
    start4 = 1'b0;
    finish4(tag, a, b, cyc, d0);
  endtask

  task automatic run8(input int unsigned a, input int unsigned b, input string tag);
    int cyc, d0;
    int unsigned q, r, z;
    @(negedge clk);
    start8 = 1'b1; dvd8 = 8'(a); dvs8 = 8'(b);
    d0 = done_cnt8;
    @(posedge clk); #1;
    start8 = 1'b0;
    chk({tag, "_busy"}, busy8, 1);
    if (b != 0) chk({tag, "_hold_q"}, quo8, prev_q8);
    cyc = 0;
    while (!done8 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    model(8, a, b, q, r, z);
    chk({tag, "_lat"}, cyc, (b == 0) ? 0 : 8);
    chk({tag, "_quo"}, quo8, q);
    chk({tag, "_rem"}, rem8, r);
    chk({tag, "_dbz"}, dbz8, z);
    prev_q8 = q; prev_r8 = r; prev_z8 = z;
    @(posedge clk); #1;
    chk({tag, "_done_once"}, done_cnt8 - d0, 1);
    chk({tag, "_idle"}, busy8, 0);
  endtask

  initial begin
    int cyc, d0;
    #12;
    chk("rst_quo", quo4, 0);
    chk("rst_rem", rem4, 0);
    chk("rst_flags", {busy4, done4, dbz4}, 0);
    chk("rst_w8", {quo8, rem8, busy8, done8, dbz8}, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("idle_no_start", busy4, 0);

    run4(10, 6, 1'b0, "d10_6");
    run4(15, 1, 1'b0, "d15_1");
    run4(3, 7, 1'b0, "d3_7");
    run4(9, 0, 1'b0, "dz9");
    run4(8, 2, 1'b0, "d8_2");
    run4(12, 5, 1'b1, "ign12_5");

    // start held high: exactly one idle cycle between successive operations
    @(negedge clk);
    start4 = 1'b1; dvd4 = 4'd15; dvs4 = 4'd1; d0 = done_cnt4;
    @(posedge clk); #1;
    chk("b2b1_busy", busy4, 1);
    wait4(1'b0, cyc);
    chk("b2b1_lat", cyc, 4);
    chk("b2b1_quo", quo4, 15);
    chk("b2b1_rem", rem4, 0);
    dvd4 = 4'd3; dvs4 = 4'd7;
    @(posedge clk); #1;
    chk("b2b_idle_gap", {busy4, done4}, 0);
    @(posedge clk); #1;
    chk("b2b2_accept", busy4, 1);
    d0 = done_cnt4;
    wait4(1'b0, cyc);
    start4 = 1'b0;
    finish4("b2b2", 3, 7, cyc, d0);

    // async reset landing between edges in the second CALC iteration
    @(negedge clk);
    start4 = 1'b1; dvd4 = 4'd12; dvs4 = 4'd5;
    @(posedge clk); #1; start4 = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("arst_outs", {quo4, rem4, dbz4}, 0);
    chk("arst_flags", {busy4, done4}, 0);
    @(negedge clk); rst = 1'b0;
    prev_q4 = 0; prev_r4 = 0; prev_z4 = 0;
    prev_q8 = 0; prev_r8 = 0; prev_z8 = 0;
    run4(10, 3, 1'b0, "post_rst");

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        run4(a, b, 1'b0, $sformatf("sw%0d_%0d", a, b));

    run8(200, 13, "w8_200_13");
    run8(77, 0, "w8_dz");
    run8(255, 255, "w8_255");
    for (int i = 0; i < 40; i++) begin
      int unsigned a, b;
      a = $urandom_range(0, 255);
      b = (i % 8 == 0) ? 0 : $urandom_range(1, 255);
      run8(a, b, $sformatf("w8r%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
